// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the decade counter slice.
//   BCD_MAX / BCD_MIN : decade end values
//   bcd_sanitize()    : maps a non-decimal nibble to 0
//   bcd_is_valid()    : 1 when a nibble is a legal decimal digit
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic bcd_is_valid(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

  function automatic logic [3:0] bcd_sanitize(input logic [3:0] nibble);
    return bcd_is_valid(nibble) ? nibble : BCD_MIN;
  endfunction

endpackage

// File: rtl/bcd_counter_n_if.sv
// Control/data bundle of one bcd_counter_n instance.
//   E, L, Up : count enable, parallel load, direction (master -> counter)
//   R        : load value, one BCD nibble per digit (master -> counter)
//   Q        : current count (counter -> master)
//   Cout     : terminal count, combinational (counter -> master)
//   LoadErr  : one-cycle flag after a load holding a non-BCD nibble
interface bcd_counter_n_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  E;
  logic                  L;
  logic                  Up;
  logic [4*DIGITS-1:0]   R;
  logic [4*DIGITS-1:0]   Q;
  logic                  Cout;
  logic                  LoadErr;

  modport master (
    output E, L, Up, R,
    input  Q, Cout, LoadErr
  );

  modport slave (
    input  E, L, Up, R,
    output Q, Cout, LoadErr
  );
endinterface

// File: rtl/bcd_digit.sv
// One BCD decade.
//   Clock, Clear : rising-edge clock, asynchronous active-low reset
//   L, D         : synchronous load of D (already sanitised by the caller)
//   Inc, Dec     : step up/down; 9 -> 0 on Inc, 0 -> 9 on Dec
//   Q            : digit value
//   AtMax, AtMin : Q == 9 / Q == 0, used for the ripple enables
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       Clock,
  input  logic       Clear,
  input  logic       L,
  input  logic [3:0] D,
  input  logic       Inc,
  input  logic       Dec,
  output logic [3:0] Q,
  output logic       AtMax,
  output logic       AtMin
);

  logic [3:0] r_q;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_q <= '0;
    end else if (L) begin
      r_q <= D;
    end else if (Inc) begin
      r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
    end else if (Dec) begin
      r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
    end
  end

  assign Q     = r_q;
  assign AtMax = (r_q == BCD_MAX);
  assign AtMin = (r_q == BCD_MIN);

  a_inc_dec_excl : assert property (@(posedge Clock) disable iff (!Clear) !(Inc && Dec));
  a_digit_legal  : assert property (@(posedge Clock) disable iff (!Clear) bcd_is_valid(r_q));

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with parallel load, wrap or saturate at the
// ends, and a combinational terminal count for cascading.
//   Clock : rising-edge clock
//   Clear : asynchronous active-low reset (Q = 0, LoadErr = 0)
//   bus   : E, L, Up, R in; Q, Cout, LoadErr out (see bcd_counter_n_if)
// Parameters: DIGITS (1..8) decades, WRAP = 1 wraps, 0 saturates.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WRAP   = 1
) (
  input  logic              Clock,
  input  logic              Clear,
  bcd_counter_n_if.slave    bus
);

  localparam int unsigned W   = 4 * DIGITS;
  localparam bit          SAT = (WRAP == 0);

  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_at_min;
  logic [DIGITS-1:0] w_inc;
  logic [DIGITS-1:0] w_dec;
  logic [DIGITS-1:0] w_nib_bad;
  logic [W-1:0]      w_load_val;
  logic [W-1:0]      w_q;
  logic              w_all_max;
  logic              w_all_min;
  logic              w_count;
  logic              w_hold_up;
  logic              w_hold_dn;
  logic              r_load_err;

  assign w_all_max = &w_at_max;
  assign w_all_min = &w_at_min;
  assign w_count   = bus.E & ~bus.L;
  // In saturate mode the end value is sticky: suppress every digit step.
  assign w_hold_up = SAT & w_all_max;
  assign w_hold_dn = SAT & w_all_min;

  always_comb begin
    w_load_val = '0;
    w_nib_bad  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_load_val[4*i +: 4] = bcd_sanitize(bus.R[4*i +: 4]);
      w_nib_bad[i]         = ~bcd_is_valid(bus.R[4*i +: 4]);
    end
  end

  // Ripple enables: a digit steps only when every lower digit sits at the
  // rollover value for the current direction.
  always_comb begin
    logic run_max;
    logic run_min;
    w_inc   = '0;
    w_dec   = '0;
    run_max = 1'b1;
    run_min = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_inc[i] = w_count &  bus.Up & run_max & ~w_hold_up;
      w_dec[i] = w_count & ~bus.Up & run_min & ~w_hold_dn;
      run_max  = run_max & w_at_max[i];
      run_min  = run_min & w_at_min[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .Clock (Clock),
      .Clear (Clear),
      .L     (bus.L),
      .D     (w_load_val[4*g +: 4]),
      .Inc   (w_inc[g]),
      .Dec   (w_dec[g]),
      .Q     (w_q[4*g +: 4]),
      .AtMax (w_at_max[g]),
      .AtMin (w_at_min[g])
    );
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= bus.L & (|w_nib_bad);
    end
  end

  assign bus.Q       = w_q;
  assign bus.Cout    = w_count & (bus.Up ? w_all_max : w_all_min);
  assign bus.LoadErr = r_load_err;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench: a 4-digit wrapping and a 4-digit saturating counter
// share stimulus; two 2-digit counters form a cascade.
module tb_bcd_counter_n;

  logic Clock;
  logic Clear;

  bcd_counter_n_if #(.DIGITS(4)) bus_a ();
  bcd_counter_n_if #(.DIGITS(4)) bus_b ();
  bcd_counter_n_if #(.DIGITS(2)) bus_lo ();
  bcd_counter_n_if #(.DIGITS(2)) bus_hi ();

  bcd_counter_n #(.DIGITS(4), .WRAP(1)) u_a  (.Clock(Clock), .Clear(Clear), .bus(bus_a));
  bcd_counter_n #(.DIGITS(4), .WRAP(0)) u_b  (.Clock(Clock), .Clear(Clear), .bus(bus_b));
  bcd_counter_n #(.DIGITS(2), .WRAP(1)) u_lo (.Clock(Clock), .Clear(Clear), .bus(bus_lo));
  bcd_counter_n #(.DIGITS(2), .WRAP(1)) u_hi (.Clock(Clock), .Clear(Clear), .bus(bus_hi));

  assign bus_hi.E = bus_lo.Cout;

  typedef struct {
    logic [15:0] q;
    logic        lerr;
    logic        cout;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;

  localparam int unsigned MAXV = 9999;

  // Reference state as plain decimal integers.
  int unsigned va = 0, vb = 0;
  logic        lerr_a = 1'b0, lerr_b = 1'b0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v, input int unsigned n);
    logic [31:0] res = '0;
    for (int unsigned i = 0; i < n; i++) begin
      res[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return res;
  endfunction

  function automatic int unsigned load_val(input logic [15:0] r);
    int unsigned v = 0;
    for (int i = 3; i >= 0; i--) begin
      int unsigned nib = r[4*i +: 4];
      if (nib > 9) nib = 0;
      v = v * 10 + nib;
    end
    return v;
  endfunction

  function automatic logic load_bad(input logic [15:0] r);
    logic bad = 1'b0;
    for (int i = 0; i < 4; i++) if (r[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic int unsigned next_count(input int unsigned v, input bit wrap, input logic up);
    if (up) return (v == MAXV) ? (wrap ? 0 : MAXV) : v + 1;
    else    return (v == 0)    ? (wrap ? MAXV : 0) : v - 1;
  endfunction

  // Drive one cycle of inputs just after a rising edge; queue what both
  // counters must show until the next edge, then advance the model.
  task automatic step(input logic e, input logic l, input logic up, input logic [15:0] r);
    exp_t ra, rb;
    logic [31:0] tmp;
    @(posedge Clock); #1;
    bus_a.E = e; bus_a.L = l; bus_a.Up = up; bus_a.R = r;
    bus_b.E = e; bus_b.L = l; bus_b.Up = up; bus_b.R = r;
    tmp = to_bcd(va, 4); ra.q = tmp[15:0]; ra.lerr = lerr_a;
    ra.cout = e & ~l & (up ? (va == MAXV) : (va == 0));
    tmp = to_bcd(vb, 4); rb.q = tmp[15:0]; rb.lerr = lerr_b;
    rb.cout = e & ~l & (up ? (vb == MAXV) : (vb == 0));
    qa.push_back(ra);
    qb.push_back(rb);
    if (l) begin
      va = load_val(r); vb = load_val(r);
      lerr_a = load_bad(r); lerr_b = load_bad(r);
    end else begin
      lerr_a = 1'b0; lerr_b = 1'b0;
      if (e) begin
        va = next_count(va, 1'b1, up);
        vb = next_count(vb, 1'b0, up);
      end
    end
  endtask

  task automatic expect_now(input string name,
                            input logic [15:0] qa_e, input logic ca, input logic la,
                            input logic [15:0] qb_e, input logic cb, input logic lb);
    @(negedge Clock); #2;
    check({name, ".A.Q"}, bus_a.Q, qa_e);
    check({name, ".A.Cout"}, bus_a.Cout, ca);
    check({name, ".A.LoadErr"}, bus_a.LoadErr, la);
    check({name, ".B.Q"}, bus_b.Q, qb_e);
    check({name, ".B.Cout"}, bus_b.Cout, cb);
    check({name, ".B.LoadErr"}, bus_b.LoadErr, lb);
  endtask

  // Asynchronous clear between edges; Clock does not rise while it is low.
  task automatic pulse_clear(input string name);
    @(negedge Clock); #2;
    bus_a.E = 1'b0; bus_a.L = 1'b0;
    bus_b.E = 1'b0; bus_b.L = 1'b0;
    Clear = 1'b0;
    #1;
    check({name, ".A.Q"}, bus_a.Q, 16'h0000);
    check({name, ".A.LoadErr"}, bus_a.LoadErr, 1'b0);
    check({name, ".B.Q"}, bus_b.Q, 16'h0000);
    check({name, ".B.LoadErr"}, bus_b.LoadErr, 1'b0);
    va = 0; vb = 0; lerr_a = 1'b0; lerr_b = 1'b0;
    #1;
    Clear = 1'b1;
  endtask

  // Monitor: every counter output is valid each cycle; compare against queue.
  initial begin
    exp_t ea, eb;
    forever begin
      @(negedge Clock);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        check("mon.A.Q", bus_a.Q, ea.q);
        check("mon.A.LoadErr", bus_a.LoadErr, ea.lerr);
        check("mon.A.Cout", bus_a.Cout, ea.cout);
      end
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        check("mon.B.Q", bus_b.Q, eb.q);
        check("mon.B.LoadErr", bus_b.LoadErr, eb.lerr);
        check("mon.B.Cout", bus_b.Cout, eb.cout);
      end
    end
  end

  initial begin
    logic [15:0] r;
    logic [31:0] tmp;
    Clear = 1'b0;
    bus_a.E = 1'b0; bus_a.L = 1'b0; bus_a.Up = 1'b1; bus_a.R = '0;
    bus_b.E = 1'b0; bus_b.L = 1'b0; bus_b.Up = 1'b1; bus_b.R = '0;
    bus_lo.E = 1'b0; bus_lo.L = 1'b0; bus_lo.Up = 1'b1; bus_lo.R = '0;
    bus_hi.L = 1'b0; bus_hi.Up = 1'b1; bus_hi.R = '0;
    #12;
    check("reset.A.Q", bus_a.Q, 16'h0000);
    check("reset.A.LoadErr", bus_a.LoadErr, 1'b0);
    check("reset.B.Q", bus_b.Q, 16'h0000);
    #1 Clear = 1'b1;

    // Up across the top end: wrap vs saturate.
    step(1'b0, 1'b1, 1'b1, 16'h9998);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    expect_now("up_9998", 16'h9998, 1'b0, 1'b0, 16'h9998, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    expect_now("up_9999", 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    expect_now("wrap_up", 16'h0000, 1'b0, 1'b0, 16'h9999, 1'b1, 1'b0);

    // Down: borrow across decades, then the bottom end.
    step(1'b0, 1'b1, 1'b0, 16'h1000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    expect_now("dn_1000", 16'h1000, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    expect_now("dn_borrow", 16'h0999, 1'b0, 1'b0, 16'h0999, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    expect_now("dn_zero", 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    expect_now("wrap_dn", 16'h9999, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Load with a bad nibble while enabled, then counting resumes.
    step(1'b1, 1'b1, 1'b1, 16'h12A4);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    expect_now("bad_nib", 16'h1204, 1'b0, 1'b1, 16'h1204, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    expect_now("resume", 16'h1205, 1'b0, 1'b0, 16'h1205, 1'b0, 1'b0);

    // Clear mid-count, then clear while LoadErr is high.
    step(1'b0, 1'b1, 1'b1, 16'h0473);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    expect_now("ld_0473", 16'h0473, 1'b0, 1'b0, 16'h0473, 1'b0, 1'b0);
    pulse_clear("clr_mid");
    step(1'b0, 1'b1, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    expect_now("all_bad", 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
    pulse_clear("clr_lerr");

    // E=0 with Up toggling holds; load still honoured with E=0.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, logic'(i % 2), 16'($urandom));
    step(1'b0, 1'b1, 1'b0, 16'h3141);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    expect_now("ld_e0", 16'h3141, 1'b0, 1'b0, 16'h3141, 1'b0, 1'b0);

    // Cascade of two 2-digit stages: 150 up-clocks from zero.
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    pulse_clear("clr_casc");
    @(posedge Clock); #1;
    bus_lo.E = 1'b1;
    repeat (150) @(posedge Clock);
    #1 bus_lo.E = 1'b0;
    #1 check("cascade", {bus_hi.Q, bus_lo.Q}, 16'h0150);

    // Randomised traffic, biased towards the end values.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: r = 16'($urandom);
        1: begin tmp = to_bcd($urandom_range(0, 9999), 4); r = tmp[15:0]; end
        2: begin tmp = to_bcd(9990 + $urandom_range(0, 9), 4); r = tmp[15:0]; end
        default: begin tmp = to_bcd($urandom_range(0, 9), 4); r = tmp[15:0]; end
      endcase
      step(logic'($urandom_range(0, 9) < 8), logic'($urandom_range(0, 7) == 0),
           logic'($urandom_range(0, 1)), r);
      if ($urandom_range(0, 63) == 0) pulse_clear("clr_rand");
    end

    step(1'b0, 1'b0, 1'b1, 16'h0000);
    @(negedge Clock); #2;
    check("drain", qa.size() + qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
